// File: rtl/acq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : acq_pkg
// Brief   : Shared types and constants for the acquisition trigger engine:
//           FSM state encoding, trigger-type codes and default widths.
// Rev     : 1.0  initial release
// ============================================================================
package acq_pkg;

  localparam int NCH_DEF  = 4;
  localparam int SW_DEF   = 12;
  localparam int LENW_DEF = 16;
  localparam int TMOW_DEF = 24;

  localparam logic [1:0] TRIG_IMM  = 2'd0;
  localparam logic [1:0] TRIG_RISE = 2'd1;
  localparam logic [1:0] TRIG_FALL = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_A  = 2'd1,
    WAIT_B  = 2'd2,
    CAPTURE = 2'd3
  } acq_state_e;

  // The reserved trigger code behaves exactly like an immediate trigger.
  function automatic logic [1:0] norm_trig_type(input logic [1:0] t);
    return (t == 2'd3) ? TRIG_IMM : t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/acq_trig_detect.sv
`default_nettype none
// ============================================================================
// Module  : acq_trig_detect
// Brief   : Channel multiplexer plus two-phase signed threshold detector.
//           Rising : phase A = sample < lower, phase B = sample > upper.
//           Falling: phase A = sample > upper, phase B = sample < lower.
//           Immediate/reserved types never report a hit. Channel indices at
//           or beyond NCH select channel 0. Requires NCH >= 2.
// Rev     : 1.0  initial release
// ============================================================================
module acq_trig_detect
  import acq_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int SW  = SW_DEF,
  parameter int CHW = $clog2(NCH)
) (
  input  logic [NCH*SW-1:0]     samples_i,
  input  logic [CHW-1:0]        ch_i,
  input  logic signed [SW-1:0]  lower_i,
  input  logic signed [SW-1:0]  upper_i,
  input  logic [1:0]            type_i,
  output logic                  phase_a_hit_o,
  output logic                  phase_b_hit_o
);

  logic signed [SW-1:0] w_sel;
  logic                 w_below;
  logic                 w_above;

  // Select the compared channel; out-of-range indices fall back to channel 0
  always_comb begin
    w_sel = samples_i[SW-1:0];
    for (int n = 0; n < NCH; n++) begin
      if (int'(ch_i) == n) w_sel = samples_i[n*SW +: SW];
    end
  end

  assign w_below = (w_sel < lower_i);
  assign w_above = (w_sel > upper_i);

  // Map the two threshold results onto the phases of the selected edge type
  always_comb begin
    phase_a_hit_o = 1'b0;
    phase_b_hit_o = 1'b0;
    case (type_i)
      TRIG_RISE: begin
        phase_a_hit_o = w_below;
        phase_b_hit_o = w_above;
      end
      TRIG_FALL: begin
        phase_a_hit_o = w_above;
        phase_b_hit_o = w_below;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/acq_trigger_engine.sv
`default_nettype none
// ============================================================================
// Module  : acq_trigger_engine
// Brief   : Multi-channel trigger and acquisition sequencer. Arms on a pulse,
//           waits for an immediate/rising/falling trigger, then streams a
//           programmed number of sample words into the capture FIFO, with
//           overrun, abort and done reporting.
//           Optional feature macro: ACQ_AUTOTRIG_EN (auto-trigger timeout).
// Rev     : 1.0  initial release
// ============================================================================
module acq_trigger_engine
  import acq_pkg::*;
#(
  parameter int NCH  = NCH_DEF,
  parameter int SW   = SW_DEF,
  parameter int LENW = LENW_DEF,
  parameter int TMOW = TMOW_DEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     arm,
  input  logic                     abort,
  input  logic [1:0]               trig_type,
  input  logic [$clog2(NCH)-1:0]   trig_ch,
  input  logic signed [SW-1:0]     lower_thresh,
  input  logic signed [SW-1:0]     upper_thresh,
  input  logic [LENW-1:0]          cap_len,
  input  logic [TMOW-1:0]          autotrig_tmo,
  input  logic [NCH*SW-1:0]        samples_in,
  input  logic                     samples_valid,
  input  logic                     fifo_afull,
  output logic                     fifo_wr,
  output logic [NCH*SW-1:0]        fifo_data,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun,
  output logic                     auto_fired,
  output logic [LENW-1:0]          sample_count
);

  localparam int CHW = $clog2(NCH);

  logic [NCH*SW-1:0]    s_q;
  logic                 v_q;
  acq_state_e           state_q;
  logic [1:0]           type_q;
  logic [CHW-1:0]       ch_q;
  logic signed [SW-1:0] lower_q;
  logic signed [SW-1:0] upper_q;
  logic [LENW-1:0]      len_q;
  logic [LENW-1:0]      count_q;
  logic                 fifo_wr_q;
  logic [NCH*SW-1:0]    fifo_data_q;
  logic                 done_q;
  logic                 overrun_q;

  logic                 w_hit_a;
  logic                 w_hit_b;
  logic                 w_take;
  logic                 w_tmo_fire;
  logic                 w_auto_go;
  logic [LENW-1:0]      w_count_inc;

  // Stage 0: register the incoming sample word and its qualifier
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_q <= '0;
      v_q <= 1'b0;
    end else begin
      s_q <= samples_in;
      v_q <= samples_valid;
    end
  end

  acq_trig_detect #(
    .NCH (NCH),
    .SW  (SW),
    .CHW (CHW)
  ) u_detect (
    .samples_i     (s_q),
    .ch_i          (ch_q),
    .lower_i       (lower_q),
    .upper_i       (upper_q),
    .type_i        (type_q),
    .phase_a_hit_o (w_hit_a),
    .phase_b_hit_o (w_hit_b)
  );

  assign w_count_inc = (count_q == {LENW{1'b1}}) ? count_q : count_q + LENW'(1);

  // The phase-B sample is itself the first captured word, so it shares the
  // write path with the CAPTURE state.
  assign w_take    = v_q & (((state_q == WAIT_B) & w_hit_b) | (state_q == CAPTURE));
  assign w_auto_go = w_tmo_fire & ~w_take;

`ifdef ACQ_AUTOTRIG_EN
  logic [TMOW-1:0] tmo_cnt_q;
  logic            auto_fired_q;

  // Timeout counter runs only while waiting for a trigger
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt_q <= '0;
    end else if (state_q == WAIT_A || state_q == WAIT_B) begin
      tmo_cnt_q <= tmo_cnt_q + TMOW'(1);
    end else begin
      tmo_cnt_q <= '0;
    end
  end

  assign w_tmo_fire = ((state_q == WAIT_A) || (state_q == WAIT_B)) &&
                      (autotrig_tmo != '0) &&
                      (tmo_cnt_q == autotrig_tmo - TMOW'(1));
  assign auto_fired = auto_fired_q;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^autotrig_tmo;
  assign w_tmo_fire   = 1'b0;
  assign auto_fired   = 1'b0;
`endif

  // Sequencer: arm/trigger/capture control with registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      type_q      <= TRIG_IMM;
      ch_q        <= '0;
      lower_q     <= '0;
      upper_q     <= '0;
      len_q       <= '0;
      count_q     <= '0;
      fifo_wr_q   <= 1'b0;
      fifo_data_q <= '0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef ACQ_AUTOTRIG_EN
      auto_fired_q <= 1'b0;
`endif
    end else begin
      fifo_wr_q <= 1'b0;
      done_q    <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        done_q  <= (state_q != IDLE);
      end else begin
        case (state_q)
          IDLE: begin
            if (arm) begin
              type_q    <= norm_trig_type(trig_type);
              ch_q      <= trig_ch;
              lower_q   <= lower_thresh;
              upper_q   <= upper_thresh;
              len_q     <= cap_len;
              count_q   <= '0;
              overrun_q <= 1'b0;
`ifdef ACQ_AUTOTRIG_EN
              auto_fired_q <= 1'b0;
`endif
              if (norm_trig_type(trig_type) != TRIG_IMM) begin
                state_q <= WAIT_A;
              end else if (cap_len == '0) begin
                done_q <= 1'b1;
              end else begin
                state_q <= CAPTURE;
              end
            end
          end
          WAIT_A: begin
            // A phase-A hit is not a trigger, so the timeout takes precedence
            if (!w_tmo_fire && v_q && w_hit_a) state_q <= WAIT_B;
          end
          WAIT_B:  ;
          CAPTURE: ;
          default: state_q <= IDLE;
        endcase

        if (w_auto_go) begin
`ifdef ACQ_AUTOTRIG_EN
          auto_fired_q <= 1'b1;
`endif
          if (len_q == '0) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            state_q <= CAPTURE;
          end
        end

        if (w_take) begin
          if (len_q == '0) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else if (fifo_afull) begin
            state_q   <= IDLE;
            done_q    <= 1'b1;
            overrun_q <= 1'b1;
          end else begin
            fifo_wr_q   <= 1'b1;
            fifo_data_q <= s_q;
            count_q     <= w_count_inc;
            if (w_count_inc == len_q) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              state_q <= CAPTURE;
            end
          end
        end
      end
    end
  end

  assign fifo_wr      = fifo_wr_q;
  assign fifo_data    = fifo_data_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign overrun      = overrun_q;
  assign sample_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_acq_trigger_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_acq_trigger_engine
// Brief   : Self-checking bench for acq_trigger_engine. Records every driven
//           sample/valid/afull, then derives the expected FIFO stream and
//           flags by scanning that history with the trigger rules.
// Rev     : 1.0  initial release
// ============================================================================
module tb_acq_trigger_engine;

  localparam int NCH  = 4;
  localparam int SW   = 12;
  localparam int LENW = 16;
  localparam int TMOW = 24;
  localparam int CHW  = 2;
  localparam int MAXC = 20000;

  logic                    clk = 1'b0;
  logic                    rstn, arm, abort, samples_valid, fifo_afull;
  logic [1:0]              trig_type;
  logic [CHW-1:0]          trig_ch;
  logic signed [SW-1:0]    lower_thresh, upper_thresh;
  logic [LENW-1:0]         cap_len;
  logic [TMOW-1:0]         autotrig_tmo;
  logic [NCH*SW-1:0]       samples_in;
  logic                    fifo_wr, busy, done, overrun, auto_fired;
  logic [NCH*SW-1:0]       fifo_data;
  logic [LENW-1:0]         sample_count;

  acq_trigger_engine #(.NCH(NCH), .SW(SW), .LENW(LENW), .TMOW(TMOW)) dut (
    .clk(clk), .rstn(rstn), .arm(arm), .abort(abort),
    .trig_type(trig_type), .trig_ch(trig_ch),
    .lower_thresh(lower_thresh), .upper_thresh(upper_thresh),
    .cap_len(cap_len), .autotrig_tmo(autotrig_tmo),
    .samples_in(samples_in), .samples_valid(samples_valid), .fifo_afull(fifo_afull),
    .fifo_wr(fifo_wr), .fifo_data(fifo_data), .busy(busy), .done(done),
    .overrun(overrun), .auto_fired(auto_fired), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  logic [NCH*SW-1:0] hs [MAXC];
  bit                hv [MAXC];
  bit                haf[MAXC];
  logic [NCH*SW-1:0] wq[$];
  logic [NCH*SW-1:0] exp_q[$];
  int cyc = 0, n_chk = 0, n_pass = 0, done_cnt = 0;
  int gen_mode = 0, pv = 100, ramp_ch = 0, ramp_val = 0, af_limit = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Drive one cycle of samples (per gen_mode), record it, advance and observe.
  task automatic tick();
    logic [NCH*SW-1:0] s;
    int r;
    for (int c = 0; c < NCH; c++) begin
      if (gen_mode == 2) begin
        r = int'($urandom_range(0, 10)) - 5;
        s[c*SW +: SW] = SW'(r);
      end else begin
        s[c*SW +: SW] = SW'($urandom);
      end
    end
    if (gen_mode == 1) begin
      s[ramp_ch*SW +: SW] = SW'(ramp_val);
      ramp_val++;
      samples_valid = 1'b1;
    end else begin
      samples_valid = ($urandom_range(0, 99) < pv);
    end
    samples_in = s;
    fifo_afull = (af_limit >= 0) && (wq.size() >= af_limit);
    if (cyc < MAXC) begin
      hs[cyc]  = samples_in;
      hv[cyc]  = samples_valid;
      haf[cyc] = fifo_afull;
    end
    @(posedge clk);
    #1;
    if (fifo_wr) wq.push_back(fifo_data);
    if (done) done_cnt++;
    cyc++;
  endtask

  function automatic int chval(input int i, input int c);
    logic signed [SW-1:0] v;
    v = hs[i][c*SW +: SW];
    return int'(v);
  endfunction

  // Expected outcome of an acquisition armed on cycle a, obtained by scanning
  // the recorded sample stream with the trigger/capture rules.
  task automatic model(input int a, input int t, input int ch, input int lo, input int hi,
                       input int len, input int tmo,
                       output int n, output bit ovr, output bit aut, output bit fin);
    int ph, tt, c, s;
    bit ha, hb, fire, grab;
    tt = (t == 3) ? 0 : t;
    c  = (ch < NCH) ? ch : 0;
    n = 0; ovr = 0; aut = 0; fin = 0;
    exp_q.delete();
    if (tt == 0 && len == 0) begin
      fin = 1;
      return;
    end
    ph = (tt == 0) ? 2 : 0;
    for (int i = a; (i + 1 < cyc) && !fin; i++) begin
      s    = chval(i, c);
      ha   = hv[i] && ((tt == 1) ? (s < lo) : (s > hi));
      hb   = hv[i] && ((tt == 1) ? (s > hi) : (s < lo));
      fire = (tmo != 0) && (i - a == tmo - 1);
      grab = 0;
      if (ph == 0) begin
        if (fire) begin aut = 1; ph = 2; fin = (len == 0); end
        else if (ha) ph = 1;
      end else if (ph == 1) begin
        if (hb) grab = 1;
        else if (fire) begin aut = 1; ph = 2; fin = (len == 0); end
      end else begin
        grab = hv[i];
      end
      if (grab) begin
        ph = 2;
        if (len == 0) fin = 1;
        else if (haf[i+1]) begin ovr = 1; fin = 1; end
        else begin
          exp_q.push_back(hs[i]);
          n++;
          fin = (n == len);
        end
      end
    end
  endtask

  task automatic acquire(input string tag, input int t, input int ch, input int lo, input int hi,
                         input int len, input int tmo, input int maxc);
    int a, n, mtmo;
    bit ovr, aut, fin;
    trig_type = 2'(t); trig_ch = CHW'(ch);
    lower_thresh = SW'(lo); upper_thresh = SW'(hi);
    cap_len = LENW'(len); autotrig_tmo = TMOW'(tmo);
    wq.delete();
    done_cnt = 0;
    a = cyc;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    trig_type = 2'($urandom); trig_ch = CHW'($urandom);
    lower_thresh = SW'($urandom); upper_thresh = SW'($urandom);
    cap_len = LENW'($urandom);
    for (int k = 0; k < maxc && done_cnt == 0; k++) tick();
    repeat (3) tick();
`ifdef ACQ_AUTOTRIG_EN
    mtmo = tmo;
`else
    mtmo = 0;
`endif
    model(a, t, ch, lo, hi, len, mtmo, n, ovr, aut, fin);
    chk({tag, " done_cnt"}, 64'(done_cnt), 64'(fin ? 1 : 0));
    chk({tag, " busy"}, 64'(busy), 64'(fin ? 0 : 1));
    chk({tag, " nwrites"}, 64'(wq.size()), 64'(exp_q.size()));
    for (int i = 0; i < wq.size() && i < exp_q.size(); i++)
      chk($sformatf("%s word%0d", tag, i), 64'(wq[i]), 64'(exp_q[i]));
    chk({tag, " sample_count"}, 64'(sample_count), 64'(n));
    chk({tag, " overrun"}, 64'(overrun), 64'(ovr));
    chk({tag, " auto_fired"}, 64'(auto_fired), 64'(aut));
    if (busy) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    af_limit = -1;
  endtask

  initial begin
    logic [SW-1:0] first;
    int len, lo, hi, t;
    rstn = 1'b0; arm = 1'b0; abort = 1'b0;
    trig_type = '0; trig_ch = '0; lower_thresh = '0; upper_thresh = '0;
    cap_len = '0; autotrig_tmo = '0; samples_in = '0; samples_valid = 1'b0; fifo_afull = 1'b0;
    repeat (3) tick();
    chk("rst fifo_wr", 64'(fifo_wr), 64'(0));
    chk("rst fifo_data", 64'(fifo_data), 64'(0));
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst done", 64'(done), 64'(0));
    chk("rst overrun", 64'(overrun), 64'(0));
    chk("rst auto_fired", 64'(auto_fired), 64'(0));
    chk("rst sample_count", 64'(sample_count), 64'(0));
    rstn = 1'b1;
    repeat (2) tick();

    // T1: immediate, 8 words, valid every cycle
    gen_mode = 0; pv = 100;
    acquire("T1", 0, 0, 0, 0, 8, 0, 50);
    chk("T1 count8", 64'(sample_count), 64'(8));

    // T2: rising on ch1, ramp -20..+20 -> first word carries 11 on ch1
    gen_mode = 1; ramp_ch = 1; ramp_val = -20;
    acquire("T2", 1, 1, -10, 10, 8, 0, 80);
    first = (wq.size() > 0) ? wq[0][SW +: SW] : '1;
    chk("T2 first", 64'(first), 64'(12'd11));

    // T3: falling on ch3, samples stay inside thresholds, then abort
    gen_mode = 2;
    trig_type = 2'd2; trig_ch = 2'd3; lower_thresh = -12'sd10; upper_thresh = 12'sd10;
    cap_len = 16'd4; autotrig_tmo = '0;
    wq.delete(); done_cnt = 0;
    arm = 1'b1; tick(); arm = 1'b0;
    repeat (30) tick();
    chk("T3 nowrites", 64'(wq.size()), 64'(0));
    chk("T3 busy", 64'(busy), 64'(1));
    abort = 1'b1; tick(); abort = 1'b0;
    chk("T3 abort done", 64'(done_cnt), 64'(1));
    chk("T3 abort idle", 64'(busy), 64'(0));

    // T4: afull after 5 writes of a 100-word capture
    gen_mode = 0; pv = 100; af_limit = 5;
    acquire("T4", 0, 0, 0, 0, 100, 0, 200);
    chk("T4 ovr", 64'(overrun), 64'(1));
    chk("T4 count5", 64'(sample_count), 64'(5));

    // T5a: arm and abort together while idle
    gen_mode = 0;
    trig_type = 2'd0; cap_len = 16'd5;
    wq.delete(); done_cnt = 0;
    arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
    repeat (4) tick();
    chk("T5a busy", 64'(busy), 64'(0));
    chk("T5a done", 64'(done_cnt), 64'(0));
    chk("T5a nowrites", 64'(wq.size()), 64'(0));
    chk("T5a ovr kept", 64'(overrun), 64'(1));

    // T5b: second arm while waiting is ignored
    gen_mode = 2;
    trig_type = 2'd2; trig_ch = 2'd0; lower_thresh = -12'sd10; upper_thresh = 12'sd10;
    cap_len = 16'd4;
    arm = 1'b1; tick(); arm = 1'b0;
    chk("T5b ovr cleared", 64'(overrun), 64'(0));
    trig_type = 2'd0; cap_len = 16'd3;
    arm = 1'b1; tick(); arm = 1'b0;
    repeat (10) tick();
    chk("T5b busy", 64'(busy), 64'(1));
    chk("T5b nowrites", 64'(wq.size()), 64'(0));
    abort = 1'b1; tick(); abort = 1'b0;
    chk("T5b done", 64'(done_cnt), 64'(1));

    // T5c/d: zero-length captures
    gen_mode = 0; pv = 80;
    acquire("T5c", 0, 0, 0, 0, 0, 0, 20);
    acquire("T5d", 1, 2, -100, 100, 0, 0, 300);

    // T6: auto-trigger timeout with a signal that never crosses
`ifdef ACQ_AUTOTRIG_EN
    gen_mode = 2; pv = 100;
    acquire("T6", 1, 0, -10, 10, 6, 50, 120);
    chk("T6 auto", 64'(auto_fired), 64'(1));
`else
    gen_mode = 2; pv = 100;
    trig_type = 2'd1; trig_ch = 2'd0; lower_thresh = -12'sd10; upper_thresh = 12'sd10;
    cap_len = 16'd6; autotrig_tmo = 24'd50;
    wq.delete(); done_cnt = 0;
    arm = 1'b1; tick(); arm = 1'b0;
    repeat (80) tick();
    chk("T6 busy", 64'(busy), 64'(1));
    chk("T6 auto", 64'(auto_fired), 64'(0));
    chk("T6 nowrites", 64'(wq.size()), 64'(0));
    abort = 1'b1; tick(); abort = 1'b0;
    autotrig_tmo = '0;
`endif

    // Randomised acquisitions
    gen_mode = 0;
    for (int k = 0; k < 8; k++) begin
      pv  = int'($urandom_range(50, 100));
      len = int'($urandom_range(0, 20));
      lo  = -int'($urandom_range(0, 1500));
      hi  = int'($urandom_range(0, 1500));
      t   = int'($urandom_range(0, 3));
      af_limit = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
`ifdef ACQ_AUTOTRIG_EN
      acquire($sformatf("R%0d", k), t, int'($urandom_range(0, 3)), lo, hi, len,
              ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(3, 30)), 400);
`else
      acquire($sformatf("R%0d", k), t, int'($urandom_range(0, 3)), lo, hi, len, 0, 400);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
